// File: rtl/store_rmw_ctrl.sv
// Memory-access sequencer for a single-port word memory: loads, direct word stores,
// and read-modify-write for byte/halfword stores, with a bounded wait on read data.
module store_rmw_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_type,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic                  resp_err,
   output logic [31:0]           resp_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_re,
   input  logic                  mem_rvalid,
   input  logic [31:0]           mem_rdata,
   output logic                  mem_we,
   output logic [31:0]           mem_wdata
);

   typedef enum logic [1:0] {
      ST_WORD     = 2'b00,
      ST_BYTE     = 2'b01,
      ST_HALF     = 2'b10,
      ST_HALF_ALT = 2'b11
   } store_type_e;

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_e                  state_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   store_type_e             type_q;
   logic                    we_q;
   logic [31:0]             wdata_q;
   logic [31:0]             word_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    req_ready_q;
   logic                    mem_re_q;
   logic                    mem_we_q;
   logic                    resp_valid_q;
   logic                    resp_err_q;
   logic [31:0]             resp_rdata_q;
   logic [31:0]             merged_d;

   // Insert the store lanes into the word just read; a[0] is ignored for halves.
   function automatic logic [31:0] merge_word(input logic [31:0] r, input logic [31:0] d,
                                              input store_type_e t, input logic [1:0] a);
      logic [31:0] w;
      w = r;
      case (t)
         ST_WORD: w = d;
         ST_BYTE: w[{a, 3'b000} +: 8] = d[{a, 3'b000} +: 8];
         default: begin
            if (a[1]) w[31:16] = d[31:16];
            else      w[15:0]  = d[15:0];
         end
      endcase
      return w;
   endfunction

   always_comb begin
      merged_d = merge_word(mem_rdata, wdata_q, type_q, addr_q[1:0]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         type_q       <= ST_WORD;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         word_q       <= '0;
         cnt_q        <= '0;
         req_ready_q  <= 1'b0;
         mem_re_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         // NOTE: pulse outputs default low here with <=; later assignments in this block win.
         mem_we_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               req_ready_q <= 1'b1;
               if (req_valid && req_ready_q) begin
                  addr_q      <= req_addr;
                  type_q      <= store_type_e'(req_type);
                  we_q        <= req_we;
                  wdata_q     <= req_wdata;
                  cnt_q       <= '0;
                  resp_err_q  <= 1'b0;
                  req_ready_q <= 1'b0;
                  if (req_we && store_type_e'(req_type) == ST_WORD) begin
                     state_q  <= WR;
                     word_q   <= req_wdata;
                     mem_we_q <= 1'b1;
                  end else begin
                     state_q  <= RD;
                     mem_re_q <= 1'b1;
                  end
               end
            end
            RD: begin
               if (mem_rvalid) begin
                  cnt_q    <= '0;
                  mem_re_q <= 1'b0;
                  if (we_q) begin
                     state_q  <= WR;
                     word_q   <= merged_d;
                     mem_we_q <= 1'b1;
                  end else begin
                     state_q      <= RESP;
                     word_q       <= mem_rdata;
                     resp_valid_q <= 1'b1;
                     resp_rdata_q <= mem_rdata;
                  end
               end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                  state_q      <= RESP;
                  mem_re_q     <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  resp_rdata_q <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            WR: begin
               state_q      <= RESP;
               resp_valid_q <= 1'b1;
               resp_rdata_q <= word_q;
            end
            RESP: begin
               state_q     <= IDLE;
               resp_err_q  <= 1'b0;
               req_ready_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign mem_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign mem_re     = mem_re_q;
   assign mem_we     = mem_we_q;
   assign mem_wdata  = word_q;

endmodule

// File: doc/store_rmw_ctrl.md
Name: store_rmw_ctrl

Overview:
Memory-access sequencer between the execute/memory stage and a single-port, word-wide data memory with variable read latency. Loads perform one word read. Word stores write directly. Byte and halfword stores do a read-modify-write: read the word, merge the store lanes into it, write it back. A single request is outstanding at a time, with a timeout on the memory read.

Parameters:
ADDR_WIDTH, 32, byte-address width of the request and memory address.
TIMEOUT, 255, maximum cycles in RD waiting for mem_rvalid; 0 disables the timeout.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = store, 0 = load
req_type  in  2  StoreType: 00 word, 01 byte, 10 half, 11 treated as half
req_addr  in  ADDR_WIDTH  byte address; bits [1:0] select lanes
req_wdata  in  32  store data, already lane-positioned (rd2)
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  valid with resp_valid; read timed out
resp_rdata  out  32  load: raw read word; store: word written
mem_addr  out  ADDR_WIDTH  word address {req_addr[AW-1:2],2'b00}
mem_re  out  1  read request, held until mem_rvalid
mem_rvalid  in  1  read data valid this cycle
mem_rdata  in  32  read word
mem_we  out  1  one-cycle write strobe
mem_wdata  out  32  word to write

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset: state IDLE, timeout counter 0, and all registered fields (address, type, we, wdata, captured word) cleared. Outputs: req_ready=0, mem_re=0, mem_we=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_wdata=0. req_ready=1 from the first cycle after reset is released.
- Reset mid-operation abandons the access. No mem_we is issued after reset is sampled.
- Acceptance: a request is taken when req_valid && req_ready, and only in IDLE. All request fields are registered at acceptance; later input changes are ignored.
- States: IDLE, RD, WR, RESP.
- IDLE: req_ready=1.
  - On acceptance, a load or a sub-word store goes to RD.
  - On acceptance, a word store (type 00) goes to WR, with the merged word = req_wdata.
- RD: mem_re=1, mem_addr=registered word address.
  - If mem_rvalid is sampled in RD (the earliest is the first RD cycle): capture mem_rdata and clear the counter. A load goes to RESP; a store goes to WR.
  - Otherwise the counter increments. When TIMEOUT!=0 and the counter reaches TIMEOUT with no rvalid: go to RESP with the error flag set, no write performed, resp_rdata=0.
- WR: mem_we=1 for exactly one cycle, mem_wdata=merged word, mem_addr held. Next state RESP.
- RESP: resp_valid=1 and resp_err=error flag for one cycle. req_ready=0. Next state IDLE. The error flag clears on leaving RESP.
- req_ready=0 in RD, WR and RESP. Back-to-back requests are accepted every 3 cycles for word stores and every ≥3 cycles otherwise.
- Merge (R = captured word, D = registered wdata, a = addr[1:0]):
  - Byte: only lane a (bits 8a+7:8a) is taken from D; all other lanes come from R.
  - Half: a[1]=0 takes D[15:0] with R[31:16]; a[1]=1 takes D[31:16] with R[15:0]. a[0] is ignored.
  - Type 11 merges as half.
  - Word: D.
- Misalignment is not detected; the lanes follow the rules above.
- mem_rvalid outside RD is ignored.
- Latency: word store 3 cycles from the acceptance edge to resp_valid. Load or sub-word store with read latency L (L=0 means rvalid in the first RD cycle) completes after 3+L (load) or 4+L (sub-word store) cycles.

Test Plan:
- Word store, addr 0x104, wdata 0x11223344 -> no mem_re; mem_we one cycle with mem_addr 0x104 and mem_wdata 0x11223344; resp_valid 3 cycles after acceptance, resp_rdata 0x11223344.
- Byte store, addr 0x102, wdata 0x11223344, mem_rdata 0xAABBCCDD with rvalid in the 2nd RD cycle -> mem_wdata 0xAA22CCDD at addr 0x100, resp_err 0.
- Half stores with mem_rdata 0xAABBCCDD, wdata 0x11223344: addr 0x202 -> 0x1122CCDD; addr 0x200 -> 0xAABB3344; type 11 at 0x202 -> 0x1122CCDD.
- Load, addr 0x30, mem_rdata 0xDEADBEEF after 5 wait cycles -> mem_re held 6 cycles; no mem_we; resp_rdata 0xDEADBEEF; req_ready low throughout.
- Timeout: TIMEOUT=4, byte store with mem_rvalid never asserted -> mem_re for 4 cycles; no mem_we; resp_valid with resp_err=1 and resp_rdata 0; next request accepted normally.
- Reset asserted during RD of a byte store -> next cycle IDLE with all outputs 0; mem_we never pulses; a late mem_rvalid is ignored; req_ready=1 once reset is released.
